// File: rtl/ysyx_22040632_pipe_fifo.sv
// Elastic valid/ready pipeline buffer between core stages: DEPTH-entry FIFO with
// optional empty fall-through, synchronous flush and a sticky occupancy peak.
module ysyx_22040632_pipe_fifo #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 2,
  parameter int FALLTHRU = 0,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    peak
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer happens on a side only in a cycle where valid & ready
  // are both high at the rising edge; a producer holds data stable until then.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    count_q, peak_q, count_next;
  logic             push, pop, bypass_taken;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count    = count_q;
  assign peak     = peak_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;

  always_comb begin
    bypass_taken = 1'b0;
    out_valid    = !empty && !flush;
    out_data     = mem[rp];
    if ((FALLTHRU != 0) && empty) begin
      // Empty fall-through: a consumed bypass payload never touches storage.
      bypass_taken = in_valid && out_ready;
      out_valid    = in_valid && !flush;
      out_data     = in_data;
    end
    push       = in_valid && in_ready && !flush && !bypass_taken;
    pop        = out_valid && out_ready && !empty;
    count_next = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
      peak_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp] <= in_data;
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wrap_inc(wp);
        if (pop)  rp <= wrap_inc(rp);
      end
      count_q <= count_next;
      // Peak is sticky across flushes; only reset clears it.
      if (count_next > peak_q) peak_q <= count_next;
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_pipe_fifo.sv
// Directed bench for the pipe FIFO across four configurations sharing one set of
// upstream/downstream stimulus; each scenario checks only the instance it targets.
module tb_ysyx_22040632_pipe_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, flush;
  logic [7:0] in_data;

  // a: DEPTH=4 registered, b: DEPTH=3 registered, c: DEPTH=2 fall-through, d: DEPTH=1 registered
  logic       a_in_ready, a_out_valid, a_full, a_empty;
  logic [7:0] a_out_data;
  logic [2:0] a_count, a_peak;
  logic       b_in_ready, b_out_valid, b_full, b_empty;
  logic [7:0] b_out_data;
  logic [1:0] b_count, b_peak;
  logic       c_in_ready, c_out_valid, c_full, c_empty;
  logic [7:0] c_out_data;
  logic [1:0] c_count, c_peak;
  logic       d_in_ready, d_out_valid, d_full, d_empty;
  logic [7:0] d_out_data;
  logic [0:0] d_count, d_peak;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  ysyx_22040632_pipe_fifo #(.WIDTH(8), .DEPTH(4), .FALLTHRU(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .flush(flush),
    .count(a_count), .full(a_full), .empty(a_empty), .peak(a_peak));
  ysyx_22040632_pipe_fifo #(.WIDTH(8), .DEPTH(3), .FALLTHRU(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .flush(flush),
    .count(b_count), .full(b_full), .empty(b_empty), .peak(b_peak));
  ysyx_22040632_pipe_fifo #(.WIDTH(8), .DEPTH(2), .FALLTHRU(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .flush(flush),
    .count(c_count), .full(c_full), .empty(c_empty), .peak(c_peak));
  ysyx_22040632_pipe_fifo #(.WIDTH(8), .DEPTH(1), .FALLTHRU(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .flush(flush),
    .count(d_count), .full(d_full), .empty(d_empty), .peak(d_peak));

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 8'h00;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (a_peak !== 3'd0) begin failures++; $display("FAIL reset_peak got=%0d exp=0", a_peak); end
    checks++; if ({a_in_ready, a_out_valid, a_empty, a_full} !== 4'b1010) begin
      failures++; $display("FAIL reset_flags got=%b exp=1010", {a_in_ready, a_out_valid, a_empty, a_full}); end
    checks++; if (a_out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", a_out_data); end
    next_cycle();
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(i);
      @(negedge clk);
      checks++; if (a_count !== 3'(i) || a_in_ready !== 1'b1) begin
        failures++; $display("FAIL fill_count got=%0d/%b exp=%0d/1", a_count, a_in_ready, i); end
      next_cycle();
    end
    in_data = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (a_count !== 3'd4 || a_full !== 1'b1 || a_in_ready !== 1'b0) begin
        failures++; $display("FAIL full_hold got=%0d/%b/%b exp=4/1/0", a_count, a_full, a_in_ready); end
      checks++; if (a_out_data !== 8'hA1) begin failures++; $display("FAIL full_head got=%0h exp=a1", a_out_data); end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA1 + 8'(i)) begin
        failures++; $display("FAIL drain_data got=%b/%0h exp=1/%0h", a_out_valid, a_out_data, 8'hA1 + 8'(i)); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (a_empty !== 1'b1 || a_out_valid !== 1'b0 || a_peak !== 3'd4) begin
      failures++; $display("FAIL drain_end got=%b/%b/%0d exp=1/0/4", a_empty, a_out_valid, a_peak); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 10); in_data = 8'(i);
      @(negedge clk);
      if (i > 0) begin
        checks++; if (b_count !== 2'd1 || b_out_valid !== 1'b1) begin
          failures++; $display("FAIL stream_count got=%0d/%b exp=1/1", b_count, b_out_valid); end
      end
      if (b_out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        checks++; if (b_out_data !== exp_v) begin
          failures++; $display("FAIL stream_data got=%0h exp=%0h", b_out_data, exp_v); end
      end
      if (in_valid && b_in_ready) exp_q.push_back(in_data);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_empty !== 1'b1 || exp_q.size() != 0) begin
      failures++; $display("FAIL stream_end got=%b/%0d exp=1/0", b_empty, exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_fallthru();
    do_reset();
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'h55) begin
      failures++; $display("FAIL bypass_same got=%b/%0h exp=1/55", c_out_valid, c_out_data); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (c_count !== 2'd0 || c_out_valid !== 1'b0) begin
      failures++; $display("FAIL bypass_nostore got=%0d/%b exp=0/0", c_count, c_out_valid); end
    next_cycle();
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'h55) begin
      failures++; $display("FAIL bypass_stall got=%b/%0h exp=1/55", c_out_valid, c_out_data); end
    next_cycle();
    in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    checks++; if (c_count !== 2'd1 || c_out_valid !== 1'b1 || c_out_data !== 8'h55) begin
      failures++; $display("FAIL bypass_stored got=%0d/%b/%0h exp=1/1/55", c_count, c_out_valid, c_out_data); end
    next_cycle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
      next_cycle();
    end
    in_data = 8'hEE; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_cycle got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
    next_cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 3'd0 || a_empty !== 1'b1 || a_peak !== 3'd3) begin
      failures++; $display("FAIL flush_after got=%0d/%b/%0d exp=0/1/3", a_count, a_empty, a_peak); end
    next_cycle();
    in_valid = 1'b1; in_data = 8'hC0;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hC0 || a_count !== 3'd1) begin
      failures++; $display("FAIL flush_refill got=%b/%0h/%0d exp=1/c0/1", a_out_valid, a_out_data, a_count); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hD0 + 8'(i);
      next_cycle();
    end
    rst_n = 1'b0; flush = 1'b1; in_data = 8'hD7;
    next_cycle();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 3'd0 || a_peak !== 3'd0) begin
      failures++; $display("FAIL midreset_count got=%0d/%0d exp=0/0", a_count, a_peak); end
    checks++; if (a_out_data !== 8'h00 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_out got=%0h/%b/%b exp=0/1/0", a_out_data, a_in_ready, a_out_valid); end
    next_cycle();
  endtask

  task automatic test_depth1();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h10;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (d_out_valid !== 1'((c % 2) == 1) || d_in_ready !== 1'((c % 2) == 0)) begin
        failures++; $display("FAIL d1_toggle got=%b/%b cycle=%0d", d_out_valid, d_in_ready, c); end
      if (d_out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        checks++; if (d_out_data !== exp_v) begin
          failures++; $display("FAIL d1_data got=%0h exp=%0h", d_out_data, exp_v); end
      end
      if (in_valid && d_in_ready) begin
        exp_q.push_back(in_data);
        next_cycle();
        in_data = in_data + 8'd1;
      end else begin
        next_cycle();
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_fallthru();
    test_flush();
    test_reset_mid();
    test_depth1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
